polyphase_coeff_loader: RTL and testbench

//  Sequences coefficient reloads for polyphase_filter: takes an AXI-Stream coefficient frame, writes it into

---
 rtl/polyphase_coeff_loader.sv | 216 +++++++++++++++++++++
 tb/tb_polyphase_coeff_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_coeff_loader.sv
`timescale 1ns/1ps
// polyphase_coeff_loader
// Sequences coefficient reloads for a polyphase filter. An AXI-Stream
// coefficient frame is written into the filter's coefficient memory through
// coeffs_wren/addr/wdata. The sample stream towards the filter is gated so
// that a reload only starts once no frame is partly delivered or still being
// output by the filter.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_coeff_*              coefficient stream in (one frame = NUMBER_TAPS beats)
//   s_data_* / m_data_*    sample stream, gated pass-through to the filter
//   flt_out_*              monitor of the filter output handshake (frame ends)
//   coeffs_wren/addr/wdata coefficient memory write port, 1 cycle after a beat
//   coeffs_loaded          a complete, valid coefficient set is resident
//   load_error             sticky: last frame was short or long
module polyphase_coeff_loader #(
  parameter int NUMBER_TAPS   = 32,
  parameter int RATE_CHANGE   = 8,
  parameter int COEFF_WIDTH   = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int REVERSE_ORDER = 0,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           s_coeff_tvalid,
  output logic                           s_coeff_tready,
  input  logic [COEFF_WIDTH-1:0]         s_coeff_tdata,
  input  logic                           s_coeff_tlast,
  input  logic                           s_data_tvalid,
  output logic                           s_data_tready,
  input  logic [DATA_WIDTH-1:0]          s_data_tdata,
  input  logic                           s_data_tlast,
  output logic                           m_data_tvalid,
  input  logic                           m_data_tready,
  output logic [DATA_WIDTH-1:0]          m_data_tdata,
  output logic                           m_data_tlast,
  input  logic                           flt_out_tvalid,
  input  logic                           flt_out_tready,
  input  logic                           flt_out_tlast,
  output logic                           coeffs_wren,
  output logic [$clog2(NUMBER_TAPS)-1:0] coeffs_addr,
  output logic [COEFF_WIDTH-1:0]         coeffs_wdata,
  output logic                           coeffs_loaded,
  output logic                           load_error
);

  localparam int AW = $clog2(NUMBER_TAPS);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PB = $clog2(RATE_CHANGE);
  localparam logic [AW-1:0] LAST_K  = AW'(NUMBER_TAPS - 1);
  localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_DISCARD
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   k;
  logic            in_frame;
  logic [IW-1:0]   inflight;
  logic            commit;
  logic            gate_open;
  logic            coeff_acc;
  logic            data_acc;
  logic            data_last_acc;
  logic            out_last;
  logic [AW-1:0]   addr_k;
  logic [AW-1:0]   wr_addr;

  // Gate: an open frame is always allowed to finish (RUN or DRAIN). A new
  // frame may only start in RUN with a resident set, no pending reload and
  // room in the inflight budget. A coefficient frame presented in the same
  // cycle as a new sample frame wins, so that frame does not start.
  always_comb begin
    gate_open = 1'b0;
    if (in_frame) begin
      gate_open = (state == ST_RUN) || (state == ST_DRAIN);
    end else begin
      gate_open = (state == ST_RUN) && coeffs_loaded && !s_coeff_tvalid &&
                  (inflight != INF_MAX);
    end
  end

  always_comb begin
    m_data_tvalid = gate_open && s_data_tvalid;
    s_data_tready = gate_open && m_data_tready;
    m_data_tdata  = s_data_tdata;
    m_data_tlast  = s_data_tlast;
  end

  always_comb begin
    data_acc      = m_data_tvalid && m_data_tready;
    data_last_acc = data_acc && s_data_tlast;
    out_last      = flt_out_tvalid && flt_out_tready && flt_out_tlast;
    coeff_acc     = s_coeff_tvalid && s_coeff_tready;
    addr_k        = (REVERSE_ORDER != 0) ? (LAST_K - k) : k;
  end

  // Filter coefficient layout: upper bits select the sub-filter tap, lower
  // bits the phase; beat order already matches this, so the split is a
  // straight regrouping of the beat index.
  if (PB > 0 && PB < AW) begin : g_split
    logic [AW-PB-1:0] sub_tap;
    logic [PB-1:0]    phase;
    always_comb begin
      sub_tap = addr_k[AW-1:PB];
      phase   = addr_k[PB-1:0];
      wr_addr = {sub_tap, phase};
    end
  end else begin : g_flat
    always_comb wr_addr = addr_k;
  end

  always_comb begin
    state_nx       = state;
    s_coeff_tready = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (s_coeff_tvalid) state_nx = ST_LOAD;
      end
      ST_RUN: begin
        if (s_coeff_tvalid) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!in_frame && (inflight == '0)) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        s_coeff_tready = 1'b1;
        if (coeff_acc) begin
          if (s_coeff_tlast) begin
            state_nx = (k == LAST_K) ? ST_RUN : ST_EMPTY;
          end else if (k == LAST_K) begin
            state_nx = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        s_coeff_tready = 1'b1;
        if (coeff_acc && s_coeff_tlast) state_nx = ST_EMPTY;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Beat counter and registered write port (1-cycle latency, 1 write/beat).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      k            <= '0;
      coeffs_wren  <= 1'b0;
      coeffs_addr  <= '0;
      coeffs_wdata <= '0;
    end else begin
      coeffs_wren <= coeff_acc && (state == ST_LOAD);
      if (state != ST_LOAD) begin
        k <= '0;
      end else if (coeff_acc) begin
        k            <= k + 1'b1;
        coeffs_addr  <= wr_addr;
        coeffs_wdata <= s_coeff_tdata;
      end
    end
  end

  // commit tracks the final good write, so coeffs_loaded rises only after
  // the last coefficient has actually been written.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      commit        <= 1'b0;
      coeffs_loaded <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      commit <= (state == ST_LOAD) && coeff_acc && s_coeff_tlast && (k == LAST_K);
      if ((state != ST_LOAD) && (state_nx == ST_LOAD)) begin
        coeffs_loaded <= 1'b0;
      end else if (commit) begin
        coeffs_loaded <= 1'b1;
      end
      if (commit) begin
        load_error <= 1'b0;
      end else if ((state == ST_LOAD) && coeff_acc &&
                   ((s_coeff_tlast && (k != LAST_K)) ||
                    (!s_coeff_tlast && (k == LAST_K)))) begin
        load_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame <= 1'b0;
      inflight <= '0;
    end else begin
      if (data_acc) in_frame <= !s_data_tlast;
      case ({data_last_acc, out_last})
        2'b10:   if (inflight != INF_MAX) inflight <= inflight + 1'b1;
        2'b01:   if (inflight != '0)      inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_coeff_loader.sv
`timescale 1ns/1ps
module tb_polyphase_coeff_loader;

  localparam int NT = 32;
  localparam int CW = 16;
  localparam int DW = 16;
  localparam int AW = $clog2(NT);

  logic aclk = 1'b0;
  logic aresetn;
  logic s_coeff_tvalid, s_coeff_tlast;
  logic [CW-1:0] s_coeff_tdata;
  logic s_data_tvalid, s_data_tlast, m_data_tready;
  logic [DW-1:0] s_data_tdata;
  logic flt_out_tvalid, flt_out_tready, flt_out_tlast;

  logic s_coeff_tready_f, s_data_tready_f, m_data_tvalid_f, m_data_tlast_f;
  logic [DW-1:0] m_data_tdata_f;
  logic coeffs_wren_f, coeffs_loaded_f, load_error_f;
  logic [AW-1:0] coeffs_addr_f;
  logic [CW-1:0] coeffs_wdata_f;

  logic s_coeff_tready_r, s_data_tready_r, m_data_tvalid_r, m_data_tlast_r;
  logic [DW-1:0] m_data_tdata_r;
  logic coeffs_wren_r, coeffs_loaded_r, load_error_r;
  logic [AW-1:0] coeffs_addr_r;
  logic [CW-1:0] coeffs_wdata_r;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt_f = 0;
  int wr_cnt_r = 0;
  logic [63:0] q_f[$];
  logic [63:0] q_r[$];

  always #5 aclk = ~aclk;

  polyphase_coeff_loader #(
    .NUMBER_TAPS(NT), .RATE_CHANGE(8), .COEFF_WIDTH(CW), .DATA_WIDTH(DW),
    .REVERSE_ORDER(0), .MAX_INFLIGHT(4)
  ) dut_f (
    .aclk(aclk), .aresetn(aresetn),
    .s_coeff_tvalid(s_coeff_tvalid), .s_coeff_tready(s_coeff_tready_f),
    .s_coeff_tdata(s_coeff_tdata), .s_coeff_tlast(s_coeff_tlast),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready_f),
    .s_data_tdata(s_data_tdata), .s_data_tlast(s_data_tlast),
    .m_data_tvalid(m_data_tvalid_f), .m_data_tready(m_data_tready),
    .m_data_tdata(m_data_tdata_f), .m_data_tlast(m_data_tlast_f),
    .flt_out_tvalid(flt_out_tvalid), .flt_out_tready(flt_out_tready),
    .flt_out_tlast(flt_out_tlast),
    .coeffs_wren(coeffs_wren_f), .coeffs_addr(coeffs_addr_f),
    .coeffs_wdata(coeffs_wdata_f), .coeffs_loaded(coeffs_loaded_f),
    .load_error(load_error_f)
  );

  polyphase_coeff_loader #(
    .NUMBER_TAPS(NT), .RATE_CHANGE(8), .COEFF_WIDTH(CW), .DATA_WIDTH(DW),
    .REVERSE_ORDER(1), .MAX_INFLIGHT(4)
  ) dut_r (
    .aclk(aclk), .aresetn(aresetn),
    .s_coeff_tvalid(s_coeff_tvalid), .s_coeff_tready(s_coeff_tready_r),
    .s_coeff_tdata(s_coeff_tdata), .s_coeff_tlast(s_coeff_tlast),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready_r),
    .s_data_tdata(s_data_tdata), .s_data_tlast(s_data_tlast),
    .m_data_tvalid(m_data_tvalid_r), .m_data_tready(m_data_tready),
    .m_data_tdata(m_data_tdata_r), .m_data_tlast(m_data_tlast_r),
    .flt_out_tvalid(flt_out_tvalid), .flt_out_tready(flt_out_tready),
    .flt_out_tlast(flt_out_tlast),
    .coeffs_wren(coeffs_wren_r), .coeffs_addr(coeffs_addr_r),
    .coeffs_wdata(coeffs_wdata_r), .coeffs_loaded(coeffs_loaded_r),
    .load_error(load_error_r)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every write pulse must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (coeffs_wren_f) begin
        wr_cnt_f++;
        if (q_f.size() == 0) check_eq("wr_f_unexpected", 1, 0);
        else check_eq("wr_f", {32'(coeffs_addr_f), 32'(coeffs_wdata_f)}, q_f.pop_front());
      end
      if (coeffs_wren_r) begin
        wr_cnt_r++;
        if (q_r.size() == 0) check_eq("wr_r_unexpected", 1, 0);
        else check_eq("wr_r", {32'(coeffs_addr_r), 32'(coeffs_wdata_r)}, q_r.pop_front());
      end
    end
  end

  // Drives n coefficient beats (tlast on beat last_at, 0 = never); pushes the
  // expected write for each accepted beat that falls inside the tap count.
  task automatic send_coeffs(input int n, input int base, input int last_at);
    int w;
    logic [CW-1:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      d = CW'(base + i);
      s_coeff_tvalid = 1'b1;
      s_coeff_tdata  = d;
      s_coeff_tlast  = (i + 1 == last_at);
      #1;
      w = 0;
      while (!s_coeff_tready_f && w < 200) begin
        @(negedge aclk);
        #1;
        w++;
      end
      if (!s_coeff_tready_f) begin
        check_eq("coeff_ready_timeout", 0, 1);
        break;
      end
      if (i < NT) begin
        q_f.push_back({32'(i), 32'(d)});
        q_r.push_back({32'(NT - 1 - i), 32'(d)});
      end
      @(posedge aclk);
    end
    @(negedge aclk);
    s_coeff_tvalid = 1'b0;
    s_coeff_tlast  = 1'b0;
  endtask

  task automatic data_beat(input logic last, input logic [DW-1:0] d);
    int w;
    @(negedge aclk);
    s_data_tvalid = 1'b1;
    s_data_tdata  = d;
    s_data_tlast  = last;
    m_data_tready = 1'b1;
    #1;
    w = 0;
    while (!s_data_tready_f && w < 50) begin
      @(negedge aclk);
      #1;
      w++;
    end
    check_eq("data_ready", {s_data_tready_f, s_data_tready_r}, 2'b11);
    check_eq("data_valid", {m_data_tvalid_f, m_data_tvalid_r}, 2'b11);
    check_eq("data_pass_f", {m_data_tdata_f, m_data_tlast_f}, {d, last});
    check_eq("data_pass_r", {m_data_tdata_r, m_data_tlast_r}, {d, last});
    @(posedge aclk);
    #1;
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
  endtask

  task automatic flt_pulse();
    @(negedge aclk);
    flt_out_tvalid = 1'b1;
    flt_out_tready = 1'b1;
    flt_out_tlast  = 1'b1;
    @(negedge aclk);
    flt_out_tvalid = 1'b0;
    flt_out_tready = 1'b0;
    flt_out_tlast  = 1'b0;
  endtask

  // Checks after a complete good load returned from send_coeffs.
  task automatic good_load_checks(input string tag, input int c_f, input int c_r);
    check_eq({tag, "_loaded_early"}, {coeffs_loaded_f, coeffs_loaded_r}, 2'b00);
    @(negedge aclk);
    check_eq({tag, "_loaded"}, {coeffs_loaded_f, coeffs_loaded_r}, 2'b11);
    check_eq({tag, "_error"}, {load_error_f, load_error_r}, 2'b00);
    repeat (2) @(negedge aclk);
    check_eq({tag, "_writes_f"}, wr_cnt_f - c_f, NT);
    check_eq({tag, "_writes_r"}, wr_cnt_r - c_r, NT);
    check_eq({tag, "_sb_empty"}, q_f.size() + q_r.size(), 0);
  endtask

  initial begin
    int c_f;
    int c_r;
    aresetn = 1'b0;
    s_coeff_tvalid = 1'b0; s_coeff_tdata = '0; s_coeff_tlast = 1'b0;
    s_data_tvalid = 1'b0; s_data_tdata = '0; s_data_tlast = 1'b0;
    m_data_tready = 1'b0;
    flt_out_tvalid = 1'b0; flt_out_tready = 1'b0; flt_out_tlast = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    check_eq("rst_wren", {coeffs_wren_f, coeffs_wren_r}, 2'b00);
    check_eq("rst_addr", {coeffs_addr_f, coeffs_addr_r}, '0);
    check_eq("rst_flags", {coeffs_loaded_f, load_error_f, coeffs_loaded_r, load_error_r}, 4'b0000);
    check_eq("rst_ready", {s_coeff_tready_f, s_coeff_tready_r, s_data_tready_f, m_data_tvalid_f}, 4'b0000);
    aresetn = 1'b1;

    // 1/2: forward and reverse addressing of full loads
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    send_coeffs(32, 0, 32);
    good_load_checks("t1", c_f, c_r);
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    send_coeffs(32, 1, 32);
    good_load_checks("t2", c_f, c_r);

    // 3: reload requested mid-frame; frame completes, then drain waits for filter tlast
    repeat (2) data_beat(1'b0, 16'h1000);
    data_beat(1'b0, 16'h1002);
    s_coeff_tvalid = 1'b1;
    s_coeff_tdata  = CW'(200);
    for (int b = 3; b < 8; b++) data_beat(b == 7, DW'(16'h1000 + b));
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    @(negedge aclk);
    s_data_tvalid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      check_eq("t3_gate_closed", {m_data_tvalid_f, s_data_tready_f, m_data_tvalid_r}, 3'b000);
      check_eq("t3_no_load", {s_coeff_tready_f, s_coeff_tready_r}, 2'b00);
    end
    flt_pulse();
    check_eq("t3_no_wren_before", wr_cnt_f - c_f, 0);
    s_data_tvalid = 1'b0;
    send_coeffs(32, 200, 32);
    good_load_checks("t3", c_f, c_r);

    // 4: short frame
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    send_coeffs(10, 300, 10);
    repeat (2) @(negedge aclk);
    check_eq("t4_writes", wr_cnt_f - c_f, 10);
    check_eq("t4_flags", {coeffs_loaded_f, load_error_f, coeffs_loaded_r, load_error_r}, 4'b0101);
    s_data_tvalid = 1'b1;
    m_data_tready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check_eq("t4_gate_closed", {s_data_tready_f, m_data_tvalid_f, s_data_tready_r}, 3'b000);
    end
    s_data_tvalid = 1'b0;
    check_eq("t4_sb_empty", q_f.size() + q_r.size(), 0);

    // 5: long frame, beats past the tap count consumed without writes
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    send_coeffs(40, 400, 40);
    repeat (3) @(negedge aclk);
    check_eq("t5_writes_f", wr_cnt_f - c_f, NT);
    check_eq("t5_writes_r", wr_cnt_r - c_r, NT);
    check_eq("t5_flags", {coeffs_loaded_f, load_error_f, coeffs_loaded_r, load_error_r}, 4'b0101);
    check_eq("t5_idle_ready", {s_coeff_tready_f, s_coeff_tready_r}, 2'b00);
    check_eq("t5_sb_empty", q_f.size() + q_r.size(), 0);

    // 6: reset in the middle of a load, then a full reload
    send_coeffs(15, 500, 0);
    check_eq("t6_wren_pre", coeffs_wren_f, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("t6_rst_wren", {coeffs_wren_f, coeffs_wren_r}, 2'b00);
    check_eq("t6_rst_flags", {coeffs_loaded_f, load_error_f, coeffs_loaded_r, load_error_r}, 4'b0000);
    check_eq("t6_rst_addr_ready", {coeffs_addr_f, s_coeff_tready_f, m_data_tvalid_f}, '0);
    q_f.delete();
    q_r.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    c_f = wr_cnt_f; c_r = wr_cnt_r;
    send_coeffs(32, 600, 32);
    good_load_checks("t6", c_f, c_r);

    // Inflight limit: four frames outstanding block the fifth until one drains
    for (int f = 0; f < 4; f++) data_beat(1'b1, DW'(16'h2000 + f));
    @(negedge aclk);
    s_data_tvalid = 1'b1;
    s_data_tlast  = 1'b1;
    #1;
    check_eq("inflight_block", {m_data_tvalid_f, s_data_tready_f}, 2'b00);
    flt_pulse();
    #1;
    check_eq("inflight_reopen", {m_data_tvalid_f, s_data_tready_f}, 2'b11);
    @(negedge aclk);
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
    repeat (2) @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
